// File: rtl/sys_rst_seq.sv
// sys_rst_seq: multi-channel reset sequencer.
// All N_CH active-low channel resets assert together. They stay asserted for at
// least MIN_ASSERT quiet cycles, then release in ascending order, STAGE_DLY
// cycles apart. A reset cause is any of: the software hold (set by Sw_on,
// cleared by Sw_off), the synchronised external request, or a watchdog trip.
// Optional feature: define SYS_RST_WDOG_EN to enable the RUN-state watchdog.
// Without it, Kick is ignored and Wdog_fired is tied low.
module sys_rst_seq #(
    parameter int N_CH        = 4,
    parameter int MIN_ASSERT  = 16,
    parameter int STAGE_DLY   = 8,
    parameter int SYNC_STAGES = 2,
    parameter int WDOG_CYC    = 1024
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Ext_rst_n,
    input  logic            Sw_on,
    input  logic            Sw_off,
    input  logic            Kick,
    output logic [N_CH-1:0] Rst_n,
    output logic            Busy,
    output logic            Ready,
    output logic            Wdog_fired
);

    localparam int MAX_AS  = (MIN_ASSERT > STAGE_DLY) ? MIN_ASSERT : STAGE_DLY;
    localparam int MAX_CYC = (MAX_AS > WDOG_CYC) ? MAX_AS : WDOG_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int STG_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_ASSERT - 1);
    localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STAGE_DLY - 1);
    localparam logic [STG_W-1:0] CH_LAST  = STG_W'(N_CH - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_e                 state_q,   state_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic [STG_W-1:0]       stage_q,   stage_d;
    logic [N_CH-1:0]        rst_n_q,   rst_n_d;
    logic                   busy_q,    busy_d;
    logic                   ready_q,   ready_d;
    logic                   sw_hold_q, sw_hold_d;
    logic [SYNC_STAGES-1:0] sync_q,    sync_d;

    logic ext_sync;
    logic wdog_trip;
    logic cause;

    assign ext_sync = sync_q[SYNC_STAGES-1];
    assign cause    = sw_hold_q | ~ext_sync | wdog_trip;

`ifdef SYS_RST_WDOG_EN
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYC - 1);

    logic [CNT_W-1:0] wdog_cnt_q,   wdog_cnt_d;
    logic             wdog_fired_q, wdog_fired_d;

    // Watchdog: counts RUN cycles since the last Kick; Kick beats a same-cycle timeout.
    always_comb begin
        wdog_cnt_d   = '0;
        wdog_fired_d = 1'b0;
        if (state_q == ST_RUN && !cause) begin
            if (Kick) begin
                wdog_cnt_d = '0;
            end else if (wdog_cnt_q == WDOG_LAST) begin
                wdog_fired_d = 1'b1;
            end else begin
                wdog_cnt_d = sat_inc(wdog_cnt_q);
            end
        end
    end

    // The one-cycle expiry pulse doubles as the reset cause on the following edge.
    assign wdog_trip  = wdog_fired_q;
    assign Wdog_fired = wdog_fired_q;
`else
    logic unused_kick;

    assign unused_kick = Kick;
    assign wdog_trip   = 1'b0;
    assign Wdog_fired  = 1'b0;
`endif

    // Next-state logic for the hold flag, synchroniser and ASSERT/RELEASE/RUN sequencer.
    always_comb begin
        // NOTE: every _d signal gets a default first, so no path through the case infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        stage_d   = stage_q;
        rst_n_d   = rst_n_q;
        sw_hold_d = Sw_on ? 1'b1 : (Sw_off ? 1'b0 : sw_hold_q);
        sync_d    = {sync_q[SYNC_STAGES-2:0], Ext_rst_n};

        unique case (state_q)
            ST_ASSERT: begin
                rst_n_d = '0;
                if (cause) begin
                    cnt_d = '0;
                end else if (cnt_q == MIN_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    stage_d = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end

            ST_RELEASE: begin
                if (cause) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    stage_d = '0;
                    rst_n_d = '0;
                end else if (cnt_q == STG_LAST) begin
                    rst_n_d[stage_q] = 1'b1;
                    cnt_d            = '0;
                    if (stage_q == CH_LAST) begin
                        state_d = ST_RUN;
                        stage_d = '0;
                    end else begin
                        stage_d = stage_q + STG_W'(1);
                    end
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end

            ST_RUN: begin
                if (cause) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    stage_d = '0;
                    rst_n_d = '0;
                end
            end

            default: begin
                state_d = ST_ASSERT;
                cnt_d   = '0;
                stage_d = '0;
                rst_n_d = '0;
            end
        endcase

        busy_d  = ~&rst_n_d;
        ready_d = (state_d == ST_RUN);
    end

    // Register bank; every output is taken straight from one of these flops.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            // NOTE: the synchroniser resets to 0 so the external request reads as asserted until the chain fills with real samples.
            state_q   <= ST_ASSERT;
            cnt_q     <= '0;
            stage_q   <= '0;
            rst_n_q   <= '0;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
            sw_hold_q <= 1'b0;
            sync_q    <= '0;
`ifdef SYS_RST_WDOG_EN
            wdog_cnt_q   <= '0;
            wdog_fired_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stage_q   <= stage_d;
            rst_n_q   <= rst_n_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            sw_hold_q <= sw_hold_d;
            sync_q    <= sync_d;
`ifdef SYS_RST_WDOG_EN
            wdog_cnt_q   <= wdog_cnt_d;
            wdog_fired_q <= wdog_fired_d;
`endif
        end
    end

    assign Rst_n = rst_n_q;
    assign Busy  = busy_q;
    assign Ready = ready_q;

endmodule

// File: tb/tb_sys_rst_seq.sv
// Testbench for sys_rst_seq.
// Reference model: a cause is computed on every edge from the input history.
// "quiet" counts consecutive cause-free edges. Channel k is released once
// quiet >= MIN_ASSERT + (k+1)*STAGE_DLY. Ready means every channel is released.
// The external request reaches the cause only after SYNC_STAGES edges, and the
// synchroniser powers up reading "asserted". So the first power-up release is
// SYNC_STAGES edges later than a software-driven one.
module tb_sys_rst_seq;

    localparam int N_CH        = 4;
    localparam int MIN_ASSERT  = 16;
    localparam int STAGE_DLY   = 8;
    localparam int SYNC_STAGES = 2;
    localparam int WDOG_CYC    = 32;
    localparam int FULL        = MIN_ASSERT + N_CH * STAGE_DLY;

`ifdef SYS_RST_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic            Clk       = 1'b0;
    logic            Rst       = 1'b1;
    logic            Ext_rst_n = 1'b1;
    logic            Sw_on     = 1'b0;
    logic            Sw_off    = 1'b0;
    logic            Kick      = 1'b0;
    logic [N_CH-1:0] Rst_n;
    logic            Busy;
    logic            Ready;
    logic            Wdog_fired;

    int checks  = 0;
    int errors  = 0;
    int edge_no = 0;

    // reference model state
    int                     quiet;
    bit                     hold;
    bit [SYNC_STAGES-1:0]   hist;
    int                     wd;
    bit                     fired;

    sys_rst_seq #(
        .N_CH       (N_CH),
        .MIN_ASSERT (MIN_ASSERT),
        .STAGE_DLY  (STAGE_DLY),
        .SYNC_STAGES(SYNC_STAGES),
        .WDOG_CYC   (WDOG_CYC)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Ext_rst_n (Ext_rst_n),
        .Sw_on     (Sw_on),
        .Sw_off    (Sw_off),
        .Kick      (Kick),
        .Rst_n     (Rst_n),
        .Busy      (Busy),
        .Ready     (Ready),
        .Wdog_fired(Wdog_fired)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        quiet = 0;
        hold  = 1'b0;
        hist  = '0;
        wd    = 0;
        fired = 1'b0;
    endtask

    task automatic model_edge(input bit on, input bit off, input bit ext, input bit kick);
        bit cause;
        bit ready_pre;
        bit fire;
        cause     = hold || !hist[SYNC_STAGES-1] || fired;
        ready_pre = (quiet >= FULL);
        fire      = 1'b0;
        if (WDOG_ON && ready_pre && !cause) begin
            if (kick) wd = 0;
            else if (wd == WDOG_CYC - 1) begin
                fire = 1'b1;
                wd   = 0;
            end else wd++;
        end else begin
            wd = 0;
        end
        quiet = cause ? 0 : ((quiet < 1_000_000) ? quiet + 1 : quiet);
        hold  = on ? 1'b1 : (off ? 1'b0 : hold);
        hist  = {hist[SYNC_STAGES-2:0], ext};
        fired = fire;
    endtask

    function automatic logic [N_CH-1:0] exp_rst_n();
        logic [N_CH-1:0] r;
        for (int k = 0; k < N_CH; k++) r[k] = (quiet >= MIN_ASSERT + (k + 1) * STAGE_DLY);
        return r;
    endfunction

    function automatic logic exp_ready();
        return (quiet >= FULL);
    endfunction

    task automatic step(input bit on, input bit off, input bit ext, input bit kick);
        Sw_on     = on;
        Sw_off    = off;
        Ext_rst_n = ext;
        Kick      = kick;
        @(posedge Clk);
        model_edge(on, off, ext, kick);
        edge_no++;
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Sw_on = 1'b0; Sw_off = 1'b0; Kick = 1'b0; Ext_rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1;
            checks++;
            if ({Rst_n, Ready, Busy, Wdog_fired} !== {{N_CH{1'b0}}, 1'b0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reset cycle %0d: got rst_n=%b ready=%b busy=%b wdog=%b, expected rst_n=0 ready=0 busy=1 wdog=0",
                         i, Rst_n, Ready, Busy, Wdog_fired);
            end
            Sw_on = 1'($urandom); Sw_off = 1'($urandom); Kick = 1'($urandom);
        end
        Sw_on = 1'b0; Sw_off = 1'b0; Kick = 1'b0;
        @(negedge Clk);
        Rst     = 1'b0;
        edge_no = 0;
    endtask

    task automatic test_power_up();
        int first_b0  = -1;
        int first_rdy = -1;
        for (int i = 0; i < SYNC_STAGES + FULL + 10; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            checks++;
            if ({Rst_n, Ready, Busy, Wdog_fired} !== {exp_rst_n(), exp_ready(), ~exp_ready(), fired}) begin
                errors++;
                $display("FAIL power_up edge %0d: got rst_n=%b ready=%b busy=%b wdog=%b, expected rst_n=%b ready=%b busy=%b wdog=%b",
                         edge_no, Rst_n, Ready, Busy, Wdog_fired, exp_rst_n(), exp_ready(), ~exp_ready(), fired);
            end
            if (first_b0 < 0 && Rst_n[0] === 1'b1) first_b0 = edge_no;
            if (first_rdy < 0 && Ready === 1'b1) first_rdy = edge_no;
        end
        checks++;
        if (first_b0 != SYNC_STAGES + MIN_ASSERT + STAGE_DLY) begin
            errors++;
            $display("FAIL power_up_bit0_edge: got %0d, expected %0d", first_b0, SYNC_STAGES + MIN_ASSERT + STAGE_DLY);
        end
        checks++;
        if (first_rdy != SYNC_STAGES + FULL) begin
            errors++;
            $display("FAIL power_up_ready_edge: got %0d, expected %0d", first_rdy, SYNC_STAGES + FULL);
        end
    endtask

    task automatic test_sw_hold();
        int n;
        int rel = -1;
        n = $urandom_range(30, 80);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i <= n; i++) begin
            if (i == n) step(1'b0, 1'b1, 1'b1, 1'b1);
            else        step(1'b0, 1'b0, 1'b1, 1'b1);
            checks++;
            if ({Rst_n, Ready, Busy, Wdog_fired} !== {exp_rst_n(), exp_ready(), ~exp_ready(), fired}) begin
                errors++;
                $display("FAIL sw_hold edge %0d: got rst_n=%b ready=%b busy=%b wdog=%b, expected rst_n=%b ready=%b busy=%b wdog=%b",
                         edge_no, Rst_n, Ready, Busy, Wdog_fired, exp_rst_n(), exp_ready(), ~exp_ready(), fired);
            end
        end
        for (int i = 1; i <= FULL + 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            checks++;
            if ({Rst_n, Ready, Busy, Wdog_fired} !== {exp_rst_n(), exp_ready(), ~exp_ready(), fired}) begin
                errors++;
                $display("FAIL sw_release edge %0d: got rst_n=%b ready=%b busy=%b, expected rst_n=%b ready=%b busy=%b",
                         edge_no, Rst_n, Ready, Busy, exp_rst_n(), exp_ready(), ~exp_ready());
            end
            if (rel < 0 && Rst_n[0] === 1'b1) rel = i;
        end
        checks++;
        if (rel != MIN_ASSERT + STAGE_DLY) begin
            errors++;
            $display("FAIL sw_off_to_bit0: got %0d edges, expected %0d", rel, MIN_ASSERT + STAGE_DLY);
        end
    endtask

    task automatic test_same_cycle();
        step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            checks++;
            if ({Rst_n, Ready, Busy} !== {exp_rst_n(), exp_ready(), ~exp_ready()}) begin
                errors++;
                $display("FAIL on_off_same edge %0d: got rst_n=%b ready=%b busy=%b, expected rst_n=%b ready=%b busy=%b",
                         edge_no, Rst_n, Ready, Busy, exp_rst_n(), exp_ready(), ~exp_ready());
            end
        end
        checks++;
        if (Rst_n !== '0) begin
            errors++;
            $display("FAIL on_off_same_hold: got rst_n=%b, expected 0000 (hold must win)", Rst_n);
        end
        step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < FULL + 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            checks++;
            if ({Rst_n, Ready, Busy} !== {exp_rst_n(), exp_ready(), ~exp_ready()}) begin
                errors++;
                $display("FAIL on_off_release edge %0d: got rst_n=%b ready=%b busy=%b, expected rst_n=%b ready=%b busy=%b",
                         edge_no, Rst_n, Ready, Busy, exp_rst_n(), exp_ready(), ~exp_ready());
            end
        end
    endtask

    task automatic test_sw_on_mid_release();
        int guard = 0;
        int rel   = -1;
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        while (Rst_n[0] !== 1'b1 && guard < FULL) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            guard++;
        end
        for (int i = 0; i < int'($urandom_range(0, STAGE_DLY - 2)); i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (Rst_n !== 4'b0001) begin
            errors++;
            $display("FAIL mid_release_setup: got rst_n=%b, expected 0001", Rst_n);
        end
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({Rst_n, Ready, Busy} !== {{N_CH{1'b0}}, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mid_release_assert: got rst_n=%b ready=%b busy=%b, expected rst_n=0000 ready=0 busy=1", Rst_n, Ready, Busy);
        end
        for (int i = 1; i <= FULL + 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            checks++;
            if ({Rst_n, Ready, Busy} !== {exp_rst_n(), exp_ready(), ~exp_ready()}) begin
                errors++;
                $display("FAIL mid_release_restart edge %0d: got rst_n=%b ready=%b busy=%b, expected rst_n=%b ready=%b busy=%b",
                         edge_no, Rst_n, Ready, Busy, exp_rst_n(), exp_ready(), ~exp_ready());
            end
            if (rel < 0 && Rst_n[0] === 1'b1) rel = i;
        end
        checks++;
        if (rel != MIN_ASSERT + STAGE_DLY) begin
            errors++;
            $display("FAIL mid_release_bit0: got %0d edges, expected %0d", rel, MIN_ASSERT + STAGE_DLY);
        end
    endtask

    task automatic test_ext_pulse();
        int t_low = -1;
        int t_rdy = -1;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= SYNC_STAGES + FULL + 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            checks++;
            if ({Rst_n, Ready, Busy} !== {exp_rst_n(), exp_ready(), ~exp_ready()}) begin
                errors++;
                $display("FAIL ext_pulse edge %0d: got rst_n=%b ready=%b busy=%b, expected rst_n=%b ready=%b busy=%b",
                         edge_no, Rst_n, Ready, Busy, exp_rst_n(), exp_ready(), ~exp_ready());
            end
            if (t_low < 0 && Rst_n === '0) t_low = i;
            if (t_low >= 0 && t_rdy < 0 && Ready === 1'b1) t_rdy = i;
        end
        checks++;
        if (t_low != SYNC_STAGES) begin
            errors++;
            $display("FAIL ext_assert_latency: got %0d edges, expected %0d", t_low, SYNC_STAGES);
        end
        checks++;
        if (t_rdy != SYNC_STAGES + FULL) begin
            errors++;
            $display("FAIL ext_ready_latency: got %0d edges, expected %0d", t_rdy, SYNC_STAGES + FULL);
        end
    endtask

    task automatic test_async_rst();
        int guard     = 0;
        int first_rdy = -1;
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        while (Rst_n[0] !== 1'b1 && guard < FULL) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            guard++;
        end
        #2;
        Rst = 1'b1;
        #1;
        checks++;
        if ({Rst_n, Ready, Busy, Wdog_fired} !== {{N_CH{1'b0}}, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_rst: got rst_n=%b ready=%b busy=%b wdog=%b, expected rst_n=0000 ready=0 busy=1 wdog=0",
                     Rst_n, Ready, Busy, Wdog_fired);
        end
        model_reset();
        @(negedge Clk);
        Rst     = 1'b0;
        edge_no = 0;
        for (int i = 0; i < SYNC_STAGES + FULL + 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            checks++;
            if ({Rst_n, Ready, Busy} !== {exp_rst_n(), exp_ready(), ~exp_ready()}) begin
                errors++;
                $display("FAIL async_rst_resume edge %0d: got rst_n=%b ready=%b busy=%b, expected rst_n=%b ready=%b busy=%b",
                         edge_no, Rst_n, Ready, Busy, exp_rst_n(), exp_ready(), ~exp_ready());
            end
            if (first_rdy < 0 && Ready === 1'b1) first_rdy = edge_no;
        end
        checks++;
        if (first_rdy != SYNC_STAGES + FULL) begin
            errors++;
            $display("FAIL async_rst_ready_edge: got %0d, expected %0d", first_rdy, SYNC_STAGES + FULL);
        end
    endtask

    task automatic test_watchdog();
        int t_fire = -1;
        int fires  = 0;
        for (int i = 1; i <= WDOG_CYC + 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            checks++;
            if ({Rst_n, Ready, Busy, Wdog_fired} !== {exp_rst_n(), exp_ready(), ~exp_ready(), fired}) begin
                errors++;
                $display("FAIL wdog_timeout edge %0d: got rst_n=%b ready=%b busy=%b wdog=%b, expected rst_n=%b ready=%b busy=%b wdog=%b",
                         edge_no, Rst_n, Ready, Busy, Wdog_fired, exp_rst_n(), exp_ready(), ~exp_ready(), fired);
            end
            if (t_fire < 0 && Wdog_fired === 1'b1) t_fire = i;
        end
        checks++;
        if (t_fire != WDOG_CYC) begin
            errors++;
            $display("FAIL wdog_fire_edge: got %0d, expected %0d", t_fire, WDOG_CYC);
        end
        for (int i = 0; i < FULL + 250; i++) begin
            step(1'b0, 1'b0, 1'b1, (i % 20) == 0);
            checks++;
            if ({Rst_n, Ready, Busy, Wdog_fired} !== {exp_rst_n(), exp_ready(), ~exp_ready(), fired}) begin
                errors++;
                $display("FAIL wdog_kicked edge %0d: got rst_n=%b ready=%b busy=%b wdog=%b, expected rst_n=%b ready=%b busy=%b wdog=%b",
                         edge_no, Rst_n, Ready, Busy, Wdog_fired, exp_rst_n(), exp_ready(), ~exp_ready(), fired);
            end
            if (i > FULL && Wdog_fired === 1'b1) fires++;
        end
        checks++;
        if (fires != 0) begin
            errors++;
            $display("FAIL wdog_kick_every_20: got %0d fires, expected 0", fires);
        end
    endtask

    task automatic test_random();
        bit on, off, ext, kick;
        for (int i = 0; i < 3000; i++) begin
            on   = ($urandom_range(0, 199) == 0);
            off  = ($urandom_range(0, 29) == 0);
            ext  = ($urandom_range(0, 249) != 0);
            kick = ($urandom_range(0, 24) == 0);
            step(on, off, ext, kick);
            checks++;
            if ({Rst_n, Ready, Busy, Wdog_fired} !== {exp_rst_n(), exp_ready(), ~exp_ready(), fired}) begin
                errors++;
                $display("FAIL random edge %0d: got rst_n=%b ready=%b busy=%b wdog=%b, expected rst_n=%b ready=%b busy=%b wdog=%b",
                         edge_no, Rst_n, Ready, Busy, Wdog_fired, exp_rst_n(), exp_ready(), ~exp_ready(), fired);
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_sw_hold();
        test_same_cycle();
        test_sw_on_mid_release();
        test_ext_pulse();
        test_async_rst();
`ifdef SYS_RST_WDOG_EN
        test_watchdog();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
